// File: rtl/enemy_gfx_pkg.sv
// Shared screen geometry, 3-bit palette and drawer state encoding for the enemy graphics path.
package enemy_gfx_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COLOUR_BLACK   = 3'b000;
    localparam logic [2:0] COLOUR_BLUE    = 3'b001;
    localparam logic [2:0] COLOUR_GREEN   = 3'b010;
    localparam logic [2:0] COLOUR_CYAN    = 3'b011;
    localparam logic [2:0] COLOUR_RED     = 3'b100;
    localparam logic [2:0] COLOUR_MAGENTA = 3'b101;
    localparam logic [2:0] COLOUR_YELLOW  = 3'b110;
    localparam logic [2:0] COLOUR_WHITE   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_DRAW,
        ST_HBAR,
        ST_DONE
    } drawer_state_t;

    // Number of filled bar pixels, saturated to the bar width.
    function automatic logic [4:0] bar_fill(input logic [3:0] health, input int barW,
                                            input int healthMax);
        int fill;
        fill = (int'(health) * barW) / healthMax;
        if (fill > barW) fill = barW;
        return 5'(fill);
    endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major x/y offset counter over a W x H rectangle, x fastest; shared by every drawer pass.
module sprite_scan_counter
    import enemy_gfx_pkg::*;
#(
    parameter int W = 8,
    parameter int H = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       step,
    output logic [3:0] xOff,
    output logic [4:0] yOff,
    output logic       last
);

    logic [3:0] xOff_q, xOff_d;
    logic [4:0] yOff_q, yOff_d;
    logic       xEnd;

    assign xEnd = (xOff_q == 4'(W - 1));

    always_comb begin
        xOff_d = xOff_q;
        yOff_d = yOff_q;
        if (clear) begin
            xOff_d = '0;
            yOff_d = '0;
        end else if (step) begin
            if (xEnd) begin
                xOff_d = '0;
                yOff_d = yOff_q + 5'd1;
            end else begin
                xOff_d = xOff_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xOff_q <= '0;
            yOff_q <= '0;
        end else begin
            xOff_q <= xOff_d;
            yOff_q <= yOff_d;
        end
    end

    assign xOff = xOff_q;
    assign yOff = yOff_q;
    assign last = xEnd && (yOff_q == 5'(H - 1));

endmodule

// File: rtl/enemy_sprite_drawer.sv
// Erases the enemy sprite at its previous position and redraws it, one VGA pixel write per clock.
// Optional health bar above the sprite is enabled by defining HEALTH_BAR_EN.
module enemy_sprite_drawer
    import enemy_gfx_pkg::*;
#(
    parameter int         SPRITE_W   = 8,
    parameter int         SPRITE_H   = 8,
    parameter logic [2:0] BG_COLOUR  = 3'b000,
    parameter int         HEALTH_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       drawReq,
    input  logic [7:0] enemyX,
    input  logic [6:0] enemyY,
    input  logic [2:0] colourIn,
    input  logic [3:0] health,
    input  logic [2:0] maxHealthColour,
    input  logic [2:0] currHealthColour,
    output logic [7:0] plotX,
    output logic [6:0] plotY,
    output logic [2:0] plotColour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

`ifdef HEALTH_BAR_EN
    localparam int            ERASE_ROWS = SPRITE_H + 1;
    localparam drawer_state_t AFTER_DRAW = ST_HBAR;
    logic [3:0] newHealth_q;
    logic [4:0] fill;
    assign fill = bar_fill(newHealth_q, SPRITE_W, HEALTH_MAX);
`else
    localparam int            ERASE_ROWS = SPRITE_H;
    localparam drawer_state_t AFTER_DRAW = ST_DONE;
    logic unused_hbar;
    assign unused_hbar = ^{health, maxHealthColour, currHealthColour};
`endif

    drawer_state_t state_q, state_d, emit, nextPass;
    logic [7:0] newX_q, prevX_q, srcX;
    logic [6:0] newY_q, prevY_q, srcY;
    logic [2:0] newCol_q, srcCol;
    logic       prevValid_q;
    logic [7:0] plotX_q, plotX_d;
    logic [6:0] plotY_q, plotY_d;
    logic [2:0] plotCol_q, plotCol_d;
    logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;
    logic       accept, clear, step, passEnd, pixOn, rowEnd, last;
    logic [3:0] xOff;
    logic [4:0] yOff;
    logic [8:0] pixX;
    logic [7:0] pixY;
    logic [2:0] pixCol;

    sprite_scan_counter #(.W(SPRITE_W), .H(ERASE_ROWS)) u_scan (
        .clk  (clk),
        .rst  (reset),
        .clear(clear),
        .step (step),
        .xOff (xOff),
        .yOff (yOff),
        .last (last)
    );

    // The pass emitted at the next edge: on acceptance the first pixel leaves in the same edge.
    always_comb begin
        accept = (state_q == ST_IDLE) && drawReq && !busy_q;
        srcX   = accept ? enemyX   : newX_q;
        srcY   = accept ? enemyY   : newY_q;
        srcCol = accept ? colourIn : newCol_q;
        emit   = state_q;
        if (accept) emit = prevValid_q ? ST_ERASE : ST_DRAW;
        rowEnd   = (xOff == 4'(SPRITE_W - 1));
        pixX     = '0;
        pixY     = '0;
        pixCol   = '0;
        pixOn    = 1'b0;
        passEnd  = 1'b0;
        nextPass = ST_DONE;
        case (emit)
            ST_ERASE: begin
                pixOn    = 1'b1;
                pixX     = {1'b0, prevX_q} + {5'd0, xOff};
                pixY     = (yOff == 5'(SPRITE_H)) ? {1'b0, prevY_q} - 8'd2
                                                  : {1'b0, prevY_q} + {3'd0, yOff};
                pixCol   = BG_COLOUR;
                passEnd  = last;
                nextPass = ST_DRAW;
            end
            ST_DRAW: begin
                pixOn    = 1'b1;
                pixX     = {1'b0, srcX} + {5'd0, xOff};
                pixY     = {1'b0, srcY} + {3'd0, yOff};
                pixCol   = srcCol;
                passEnd  = rowEnd && (yOff == 5'(SPRITE_H - 1));
                nextPass = AFTER_DRAW;
            end
`ifdef HEALTH_BAR_EN
            ST_HBAR: begin
                pixOn    = 1'b1;
                pixX     = {1'b0, newX_q} + {5'd0, xOff};
                pixY     = {1'b0, newY_q} - 8'd2;
                pixCol   = ({1'b0, xOff} < fill) ? currHealthColour : maxHealthColour;
                passEnd  = rowEnd;
                nextPass = ST_DONE;
            end
`endif
            default: ;
        endcase

        state_d = state_q;
        clear   = 1'b0;
        step    = 1'b0;
        case (emit)
            ST_IDLE: clear = 1'b1;
            ST_DONE: begin
                state_d = ST_IDLE;
                clear   = 1'b1;
            end
            default: begin
                if (passEnd) begin
                    state_d = nextPass;
                    clear   = 1'b1;
                end else begin
                    state_d = emit;
                    step    = 1'b1;
                end
            end
        endcase

        // Wide coordinates let off-screen pixels clip instead of wrapping onto the screen.
        plotX_d   = pixX[7:0];
        plotY_d   = pixY[6:0];
        plotCol_d = pixCol;
        plot_d    = pixOn && (pixX < 9'(SCREEN_W)) && (pixY < 8'(SCREEN_H));
        busy_d    = accept || (state_q != ST_IDLE);
        done_d    = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            plotX_q     <= '0;
            plotY_q     <= '0;
            plotCol_q   <= '0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            prevValid_q <= 1'b0;
            newX_q      <= '0;
            newY_q      <= '0;
            newCol_q    <= '0;
            prevX_q     <= '0;
            prevY_q     <= '0;
`ifdef HEALTH_BAR_EN
            newHealth_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            plotX_q   <= plotX_d;
            plotY_q   <= plotY_d;
            plotCol_q <= plotCol_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            if (accept) begin
                newX_q   <= enemyX;
                newY_q   <= enemyY;
                newCol_q <= colourIn;
`ifdef HEALTH_BAR_EN
                newHealth_q <= health;
`endif
            end
            if (state_q == ST_DONE) begin
                prevX_q     <= newX_q;
                prevY_q     <= newY_q;
                prevValid_q <= 1'b1;
            end
        end
    end

    assign plotX      = plotX_q;
    assign plotY      = plotY_q;
    assign plotColour = plotCol_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_enemy_sprite_drawer.sv
// Scoreboard bench for enemy_sprite_drawer: requests push expected pixels/done, a monitor pops them.
`timescale 1ns/1ps
module tb_enemy_sprite_drawer;

`ifdef HEALTH_BAR_EN
    localparam int BAR = 8;
`else
    localparam int BAR = 0;
`endif
    localparam int FILL = 4;  // health 4 of 8 on an 8-pixel bar

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       drawReq = 1'b0;
    logic [7:0] enemyX = '0;
    logic [6:0] enemyY = '0;
    logic [2:0] colourIn = '0;
    logic [3:0] health = 4'd4;
    logic [2:0] maxHealthColour = 3'b001;
    logic [2:0] currHealthColour = 3'b010;
    logic [7:0] plotX;
    logic [6:0] plotY;
    logic [2:0] plotColour;
    logic       plot, busy, done;

    enemy_sprite_drawer dut (
        .clk             (clk),
        .reset           (reset),
        .drawReq         (drawReq),
        .enemyX          (enemyX),
        .enemyY          (enemyY),
        .colourIn        (colourIn),
        .health          (health),
        .maxHealthColour (maxHealthColour),
        .currHealthColour(currHealthColour),
        .plotX           (plotX),
        .plotY           (plotY),
        .plotColour      (plotColour),
        .plot            (plot),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_done;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    bit  prev_v = 1'b0;
    int  prev_x = 0;
    int  prev_y = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic push_px(input int x, input int y, input logic [2:0] c);
        ev_t e;
        if (x >= 0 && x < 160 && y >= 0 && y < 120) begin
            e.is_done = 1'b0;
            e.x = 8'(x);
            e.y = 7'(y);
            e.c = c;
            exp_q.push_back(e);
        end
    endtask

    task automatic plan(input int x, input int y, input logic [2:0] c);
        ev_t e;
        if (prev_v) begin
            for (int r = 0; r < 8; r++)
                for (int i = 0; i < 8; i++) push_px(prev_x + i, prev_y + r, 3'b000);
`ifdef HEALTH_BAR_EN
            for (int i = 0; i < 8; i++) push_px(prev_x + i, prev_y - 2, 3'b000);
`endif
        end
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) push_px(x + i, y + r, c);
`ifdef HEALTH_BAR_EN
        for (int i = 0; i < 8; i++)
            push_px(x + i, y - 2, (i < FILL) ? currHealthColour : maxHealthColour);
`endif
        e = '0;
        e.is_done = 1'b1;
        exp_q.push_back(e);
        prev_v = 1'b1;
        prev_x = x;
        prev_y = y;
    endtask

    task automatic start_req(input int x, input int y, input logic [2:0] c);
        plan(x, y, c);
        enemyX   = 8'(x);
        enemyY   = 7'(y);
        colourIn = c;
        drawReq  = 1'b1;
        @(posedge clk);
        #1;
        drawReq = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(input int k0, input int exp_cycles, input string name);
        int k = k0;
        while (done !== 1'b1 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, k, exp_cycles);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!reset && (plot || done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {done, plot, plotX, plotY, plotColour}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.is_done) check("done_pulse", {done, plot}, 2'b10);
                else check("pixel", {done, plot, plotX, plotY, plotColour},
                           {2'b01, e.x, e.y, e.c});
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_plot", plot, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_coords", {plotX, plotY, plotColour}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        // First draw: no erase
        start_req(10, 20, 3'b100);
        wait_done(0, 64 + BAR, "t1_cycles");
        @(posedge clk);
        #1;
        check("t1_busy_released", busy, 0);

        // Move down: erase then draw
        start_req(10, 25, 3'b100);
        wait_done(0, 128 + 2 * BAR, "t2_cycles");

        // Request during the done cycle must wait one more cycle
        enemyX   = 8'd156;
        enemyY   = 7'd116;
        colourIn = 3'b011;
        drawReq  = 1'b1;
        @(posedge clk);
        #1;
        check("done_cycle_req_ignored", busy, 0);

        // Bottom-right corner: mostly clipped
        start_req(156, 116, 3'b011);
        wait_done(0, 128 + 2 * BAR, "t3_clipped_cycles");
        @(posedge clk);
        #1;

        // Extra request mid-pass is dropped
        start_req(30, 40, 3'b101);
        repeat (29) @(posedge clk);
        #1;
        enemyX   = 8'd50;
        enemyY   = 7'd60;
        colourIn = 3'b111;
        drawReq  = 1'b1;
        @(posedge clk);
        #1;
        drawReq = 1'b0;
        check("t4_busy_mid_pass", busy, 1);
        wait_done(30, 128 + 2 * BAR, "t4_cycles");
        @(posedge clk);
        #1;

        // Reset partway through the draw pass
        start_req(60, 50, 3'b110);
        repeat (64 + BAR + 40) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        prev_v = 1'b0;
        #1;
        check("t5_reset_plot", plot, 0);
        check("t5_reset_busy", busy, 0);
        check("t5_reset_done", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        start_req(70, 30, 3'b001);
        wait_done(0, 64 + BAR, "t5_no_erase_cycles");
        @(posedge clk);
        #1;

        // Top-left corner, bar (if any) fully clipped
        start_req(0, 0, 3'b111);
        wait_done(0, 128 + 2 * BAR, "t7_origin_cycles");

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
